// File: rtl/hash_seq_pkg.sv
// Shared types and default timing constants for the hash sweep sequencer.
package hash_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MSA   = 3'd1,
      ST_COMP  = 3'd2,
      ST_ADD   = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5
   } hash_state_e;

   localparam int MSA_CYCLES_DEF  = 48;
   localparam int COMP_CYCLES_DEF = 64;
   localparam int NUM_PASSES_DEF  = 3;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hash_cycle_counter.sv
// Phase cycle counter: counts 0..rollover_val-1 while enabled and wraps to 0
// on the last cycle, so back-to-back phases each start from zero.
module hash_cycle_counter #(
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             enable,
   input  logic             clear,
   input  logic [CNT_W-1:0] rollover_val,
   output logic             rollover_flag
);

   logic [CNT_W-1:0] count;

   assign rollover_flag = enable && (count == (rollover_val - CNT_W'(1)));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (rollover_flag) count <= '0;
         else               count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hash_sequencer.sv
// Nonce sweep sequencer: runs NUM_PASSES of MSA/COMP/ADD per nonce, then a
// CHECK against the comparator, until a hit, the count runs out, or abort.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for start; found/nonce hold last result
// MSA      | message schedule, MSA_CYCLES cycles
// COMP     | compression, COMP_CYCLES cycles
// ADD      | one-cycle feed-forward add, next pass or CHECK
// CHECK    | one-cycle target compare, next nonce or DONE
// DONE     | one-cycle done pulse
module hash_sequencer
   import hash_seq_pkg::*;
#(
   parameter int MSA_CYCLES  = MSA_CYCLES_DEF,
   parameter int COMP_CYCLES = COMP_CYCLES_DEF,
   parameter int NUM_PASSES  = NUM_PASSES_DEF,
   parameter int NONCE_W     = 32,
   localparam int PASS_W     = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic               abort,
   input  logic [NONCE_W-1:0] nonce_start,
   input  logic [NONCE_W-1:0] nonce_count,
   input  logic               target_hit,
   output logic               msa_en,
   output logic               comp_en,
   output logic               add_en,
   output logic               check_en,
   output logic [PASS_W-1:0]  pass_idx,
   output logic [NONCE_W-1:0] nonce,
   output logic               busy,
   output logic               found,
   output logic               done
);

   localparam int CNT_W = $clog2(max2(MSA_CYCLES, COMP_CYCLES) + 1);
   localparam logic [CNT_W-1:0]  MSA_ROLL  = CNT_W'(MSA_CYCLES);
   localparam logic [CNT_W-1:0]  COMP_ROLL = CNT_W'(COMP_CYCLES);
   localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

   hash_state_e        state, state_nxt;
   logic [NONCE_W-1:0] remaining;
   logic               phase_en, phase_clr, phase_roll;
   logic [CNT_W-1:0]   phase_len;
   logic               accept;

   assign accept    = (state == ST_IDLE) && start && !abort;
   assign phase_en  = (state == ST_MSA) || (state == ST_COMP);
   assign phase_len = (state == ST_MSA) ? MSA_ROLL : COMP_ROLL;
   // Every state change out of MSA/COMP coincides with a wrap or an abort,
   // so holding the counter clear elsewhere gives each phase a fresh count.
   assign phase_clr = abort || !phase_en;

   hash_cycle_counter #(.CNT_W(CNT_W)) u_cycle_counter (
      .clk           (clk),
      .n_rst         (n_rst),
      .enable        (phase_en),
      .clear         (phase_clr),
      .rollover_val  (phase_len),
      .rollover_flag (phase_roll)
   );

   always_comb begin
      state_nxt = state;
      if (abort && state != ST_IDLE) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (accept) state_nxt = (nonce_count != '0) ? ST_MSA : ST_DONE;
            ST_MSA:   if (phase_roll) state_nxt = ST_COMP;
            ST_COMP:  if (phase_roll) state_nxt = ST_ADD;
            ST_ADD:   state_nxt = (pass_idx < LAST_PASS) ? ST_MSA : ST_CHECK;
            ST_CHECK: begin
               if (target_hit || remaining == NONCE_W'(1)) state_nxt = ST_DONE;
               else                                        state_nxt = ST_MSA;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= ST_IDLE;
         msa_en    <= 1'b0;
         comp_en   <= 1'b0;
         add_en    <= 1'b0;
         check_en  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         found     <= 1'b0;
         pass_idx  <= '0;
         nonce     <= '0;
         remaining <= '0;
      end else begin
         state    <= state_nxt;
         msa_en   <= (state_nxt == ST_MSA);
         comp_en  <= (state_nxt == ST_COMP);
         add_en   <= (state_nxt == ST_ADD);
         check_en <= (state_nxt == ST_CHECK);
         busy     <= (state_nxt != ST_IDLE);
         done     <= (state_nxt == ST_DONE);

         if (abort && state != ST_IDLE) begin
            found    <= 1'b0;
            pass_idx <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     nonce     <= nonce_start;
                     remaining <= nonce_count;
                     found     <= 1'b0;
                     pass_idx  <= '0;
                  end
               end
               ST_ADD: begin
                  if (pass_idx < LAST_PASS) pass_idx <= pass_idx + PASS_W'(1);
               end
               ST_CHECK: begin
                  if (target_hit) begin
                     found <= 1'b1;
                  end else if (remaining != NONCE_W'(1)) begin
                     nonce     <= nonce + NONCE_W'(1);
                     remaining <= remaining - NONCE_W'(1);
                     pass_idx  <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hash_sequencer.sv
// Scoreboarded bench for hash_sequencer: directed sweeps with hand-computed
// done results, phase timing, abort, boundary and async reset cases.
module tb_hash_sequencer;

   localparam int MSA    = 4;
   localparam int COMP   = 5;
   localparam int PASSES = 3;

   logic        clk = 1'b0;
   logic        n_rst, start, abort, target_hit;
   logic [31:0] nonce_start, nonce_count;
   logic        msa_en, comp_en, add_en, check_en, busy, found, done;
   logic [1:0]  pass_idx;
   logic [31:0] nonce;

   logic        n_rst2, start2, abort2;
   logic        msa_en2, comp_en2, add_en2, check_en2, busy2, found2, done2;
   logic [1:0]  pass_idx2;
   logic [31:0] nonce2;

   hash_sequencer #(
      .MSA_CYCLES  (MSA),
      .COMP_CYCLES (COMP),
      .NUM_PASSES  (PASSES),
      .NONCE_W     (32)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .start       (start),
      .abort       (abort),
      .nonce_start (nonce_start),
      .nonce_count (nonce_count),
      .target_hit  (target_hit),
      .msa_en      (msa_en),
      .comp_en     (comp_en),
      .add_en      (add_en),
      .check_en    (check_en),
      .pass_idx    (pass_idx),
      .nonce       (nonce),
      .busy        (busy),
      .found       (found),
      .done        (done)
   );

   hash_sequencer dut_def (
      .clk         (clk),
      .n_rst       (n_rst2),
      .start       (start2),
      .abort       (abort2),
      .nonce_start (nonce_start),
      .nonce_count (nonce_count),
      .target_hit  (target_hit),
      .msa_en      (msa_en2),
      .comp_en     (comp_en2),
      .add_en      (add_en2),
      .check_en    (check_en2),
      .pass_idx    (pass_idx2),
      .nonce       (nonce2),
      .busy        (busy2),
      .found       (found2),
      .done        (done2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        found;
      logic [31:0] nonce;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   done2_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic start_run(input logic [31:0] ns, input logic [31:0] cnt);
      nonce_start = ns;
      nonce_count = cnt;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (n_rst === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected done", 64'(done), 64'(0));
         end else begin
            e = sb.pop_front();
            check("done found", 64'(found), 64'(e.found));
            check("done nonce", 64'(nonce), 64'(e.nonce));
         end
      end
   end

   always @(negedge clk) if (done2 === 1'b1) done2_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          nchk, ncomp, nmsa;
      logic [31:0] cn[4];
      logic [3:0]  exp_en;
      logic [1:0]  exp_pass;
      int          r;

      n_rst = 1'b0; n_rst2 = 1'b0;
      start = 1'b0; start2 = 1'b0; abort = 1'b0; abort2 = 1'b0;
      target_hit = 1'b0; nonce_start = 32'h0; nonce_count = 32'h0;
      repeat (2) tick;
      check("reset enables", 64'({msa_en, comp_en, add_en, check_en}), 64'(0));
      check("reset status", 64'({busy, found, done}), 64'(0));
      check("reset pass_idx", 64'(pass_idx), 64'(0));
      check("reset nonce", 64'(nonce), 64'(0));
      n_rst = 1'b1; n_rst2 = 1'b1;
      tick;

      // One nonce, no hit: 3 x (4 MSA, 5 COMP, 1 ADD) + 1 CHECK = 31 cycles.
      sb.push_back('{1'b0, 32'h10});
      start_run(32'h10, 32'd1);
      check("t1 busy", 64'(busy), 64'(1));
      for (int cyc = 0; cyc < 31; cyc++) begin
         r = cyc % 10;
         if (cyc == 30)  exp_en = 4'b0001;
         else if (r < 4) exp_en = 4'b1000;
         else if (r < 9) exp_en = 4'b0100;
         else            exp_en = 4'b0010;
         exp_pass = (cyc == 30) ? 2'd2 : 2'(cyc / 10);
         check("t1 phase", 64'({msa_en, comp_en, add_en, check_en}), 64'(exp_en));
         check("t1 pass_idx", 64'(pass_idx), 64'(exp_pass));
         tick;
      end
      check("t1 done after 31", 64'(done), 64'(1));
      tick;
      check("t1 done one cycle", 64'(done), 64'(0));
      check("t1 idle", 64'(busy), 64'(0));
      repeat (3) tick;
      check("t1 nonce hold", 64'(nonce), 64'(32'h10));

      // Five nonces from 0x20, hit on the third CHECK.
      sb.push_back('{1'b1, 32'h22});
      start_run(32'h20, 32'd5);
      nchk = 0;
      for (int i = 0; i < 500 && done !== 1'b1; i++) begin
         if (check_en === 1'b1) begin
            nchk++;
            target_hit = (nchk == 3);
         end else begin
            target_hit = 1'b0;
         end
         tick;
      end
      target_hit = 1'b0;
      check("t2 reached done", 64'(done), 64'(1));
      check("t2 checks", 64'(nchk), 64'(3));
      repeat (3) tick;
      check("t2 found hold", 64'(found), 64'(1));
      check("t2 nonce hold", 64'(nonce), 64'(32'h22));
      check("t2 idle", 64'(busy), 64'(0));

      // Wrap from 0xFFFFFFFF to 0.
      sb.push_back('{1'b0, 32'h0});
      start_run(32'hFFFF_FFFF, 32'd2);
      nchk = 0;
      for (int i = 0; i < 500 && done !== 1'b1; i++) begin
         if (check_en === 1'b1) begin
            if (nchk < 4) cn[nchk] = nonce;
            nchk++;
         end
         tick;
      end
      check("t3 reached done", 64'(done), 64'(1));
      check("t3 checks", 64'(nchk), 64'(2));
      check("t3 first nonce", 64'(cn[0]), 64'(32'hFFFF_FFFF));
      check("t3 second nonce", 64'(cn[1]), 64'(32'h0));
      tick;

      // Abort in the 3rd COMP cycle of pass 1; start while busy is ignored.
      start_run(32'h40, 32'd3);
      tick;
      nonce_start = 32'h99; nonce_count = 32'd7; start = 1'b1;
      tick;
      start = 1'b0;
      check("t4 start ignored nonce", 64'(nonce), 64'(32'h40));
      check("t4 still busy", 64'(busy), 64'(1));
      ncomp = 0;
      for (int i = 0; i < 200; i++) begin
         if (pass_idx == 2'd1 && comp_en === 1'b1) begin
            ncomp++;
            if (ncomp == 3) break;
         end
         tick;
      end
      check("t4 reached comp3", 64'(ncomp), 64'(3));
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("t4 abort busy", 64'(busy), 64'(0));
      check("t4 abort found", 64'(found), 64'(0));
      check("t4 abort pass_idx", 64'(pass_idx), 64'(0));
      check("t4 abort enables", 64'({msa_en, comp_en, add_en, check_en}), 64'(0));
      repeat (10) tick;
      check("t4 stays idle", 64'(busy), 64'(0));

      // nonce_count = 0 goes straight to DONE.
      sb.push_back('{1'b0, 32'h55});
      start_run(32'h55, 32'd0);
      check("t5 zero count done", 64'(done), 64'(1));
      tick;
      check("t5 done one cycle", 64'(done), 64'(0));
      check("t5 idle", 64'(busy), 64'(0));

      // start and abort together in IDLE: nothing happens.
      nonce_start = 32'h66; nonce_count = 32'd3; start = 1'b1; abort = 1'b1;
      tick;
      start = 1'b0; abort = 1'b0;
      check("t6 start+abort busy", 64'(busy), 64'(0));
      check("t6 start+abort msa", 64'(msa_en), 64'(0));
      check("t6 start+abort nonce", 64'(nonce), 64'(32'h55));
      tick;

      // Default-parameter instance: async reset mid-MSA, then a full 48-cycle MSA.
      nonce_start = 32'h77; nonce_count = 32'd1; start2 = 1'b1;
      tick;
      start2 = 1'b0;
      check("t7 msa entered", 64'(msa_en2), 64'(1));
      repeat (10) tick;
      #2 n_rst2 = 1'b0;
      #1;
      check("t7 async enables", 64'({msa_en2, comp_en2, add_en2, check_en2}), 64'(0));
      check("t7 async status", 64'({busy2, found2, done2}), 64'(0));
      check("t7 async nonce", 64'(nonce2), 64'(0));
      check("t7 async pass_idx", 64'(pass_idx2), 64'(0));
      repeat (3) tick;
      n_rst2 = 1'b1;
      tick;
      check("t7 idle after reset", 64'(busy2), 64'(0));
      start2 = 1'b1;
      tick;
      start2 = 1'b0;
      nmsa = 0;
      for (int i = 0; i < 100 && msa_en2 === 1'b1; i++) begin
         nmsa++;
         tick;
      end
      check("t7 msa length", 64'(nmsa), 64'(48));
      check("t7 comp follows", 64'(comp_en2), 64'(1));
      abort2 = 1'b1;
      tick;
      abort2 = 1'b0;
      check("t7 abort idle", 64'(busy2), 64'(0));
      repeat (2) tick;
      check("t7 no done pulse", 64'(done2_cnt), 64'(0));
      check("scoreboard drained", 64'(sb.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hash_sequencer.md
HASH_SEQUENCER -- requirements
Module: hash_sequencer

Interface
REQ-001 SHALL have parameter MSA_CYCLES, default 48, giving the message-schedule cycles per pass (minimum 1).
REQ-002 SHALL have parameter COMP_CYCLES, default 64, giving the compression cycles per pass (minimum 1).
REQ-003 SHALL have parameter NUM_PASSES, default 3, giving the hash passes per nonce (1..8).
REQ-004 SHALL have parameter NONCE_W, default 32, giving the nonce and count width.
REQ-005 SHALL have clock clk, input, 1 bit, rising-edge clock.
REQ-006 SHALL have reset n_rst, input, 1 bit, asynchronous, active-low.
REQ-007 SHALL have start, input, 1 bit, a request to begin a nonce sweep; it is sampled only in IDLE.
REQ-008 SHALL have abort, input, 1 bit, which cancels the sweep in any state.
REQ-009 SHALL have nonce_start, input, NONCE_W bits, the first nonce of the sweep.
REQ-010 SHALL have nonce_count, input, NONCE_W bits, the number of nonces to try.
REQ-011 SHALL have target_hit, input, 1 bit, the comparator result; it is sampled only in CHECK.
REQ-012 SHALL have outputs msa_en, comp_en, add_en and check_en, each 1 bit, the datapath phase enables.
REQ-013 SHALL have pass_idx, output, clog2(NUM_PASSES) bits (minimum 1), the current pass number.
REQ-014 SHALL have nonce, output, NONCE_W bits, the nonce currently in use or the last nonce used.
REQ-015 SHALL have outputs busy (1 bit, state is not IDLE), found (1 bit) and done (1 bit).

Function
REQ-016 SHALL implement states IDLE, MSA, COMP, ADD, CHECK and DONE; all outputs SHALL be decoded from registered state (Moore).
REQ-017 msa_en, comp_en, add_en and check_en SHALL be 1 exactly in MSA, COMP, ADD and CHECK respectively, so they are mutually exclusive.
REQ-018 IDLE with start=1, abort=0 and nonce_count!=0 SHALL do the following:
- latch nonce_start into nonce;
- latch nonce_count into the remaining counter;
- clear found and set pass_idx=0;
- enter MSA.
REQ-019 IDLE with start=1 and nonce_count=0 SHALL go directly to DONE with found=0 and nonce=nonce_start.
REQ-020 MSA SHALL last exactly MSA_CYCLES cycles, then go to COMP.
REQ-021 COMP SHALL last exactly COMP_CYCLES cycles, then go to ADD.
REQ-022 ADD SHALL last one cycle, then take one of two paths:
- if pass_idx<NUM_PASSES-1: increment pass_idx and go to MSA;
- otherwise: go to CHECK.
REQ-023 CHECK SHALL last one cycle and SHALL take exactly one of three paths:
- target_hit=1: go to DONE with found=1 and nonce held;
- target_hit=0 and remaining=1: go to DONE with found=0;
- otherwise: increment nonce modulo 2^NONCE_W, decrement remaining, set pass_idx=0 and go to MSA.
REQ-024 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-025 found and nonce SHALL hold their values in IDLE until the next accepted start.
REQ-026 One nonce SHALL take exactly NUM_PASSES*(MSA_CYCLES+COMP_CYCLES+1)+1 cycles, measured from MSA entry to CHECK exit.
REQ-027 abort=1 in any state other than IDLE SHALL force IDLE on the next edge, with found=0, done never asserted, and pass_idx=0.
REQ-028 abort SHALL take priority over start, over the expiry of the phase cycle counter, and over target_hit.
REQ-029 start while busy=1 SHALL be ignored.
REQ-030 The nonce increment SHALL wrap from 2^NONCE_W-1 to 0 with no flag.
REQ-031 The phase cycle counter SHALL reset to 0 on every state change, so a new phase always counts its full length.

Reset
REQ-032 While n_rst=0 the block SHALL hold these values:
- state=IDLE;
- msa_en=comp_en=add_en=check_en=0;
- pass_idx=0 and nonce=0;
- busy=found=done=0;
- phase cycle counter=0 and remaining counter=0.
REQ-033 Reset asserted in the middle of a sweep SHALL abandon the sweep, and done SHALL not be asserted.

Structure
REQ-034 Package hash_seq_pkg SHALL hold:
- the state enum typedef;
- the default constants MSA_CYCLES_DEF=48, COMP_CYCLES_DEF=64 and NUM_PASSES_DEF=3.
REQ-035 The phase cycle counting SHALL be a sub-module hash_cycle_counter with this interface:
- enable, clear, and rollover value inputs;
- rollover_flag output;
- width clog2(max(MSA_CYCLES,COMP_CYCLES)+1).
REQ-036 The nonce counter, remaining counter and pass counter SHALL stay in hash_sequencer.

Verification
REQ-037 Parameters MSA=4, COMP=5, PASSES=3, one nonce: start, nonce_start=0x10, nonce_count=1, target_hit=0 -> the following response:
- msa_en=1 for 4 cycles, comp_en=1 for 5, add_en=1 for 1, repeated for pass_idx 0,1,2;
- then check_en=1 for 1 cycle;
- then done=1, found=0, nonce=0x10;
- 31 cycles from MSA entry to CHECK exit.
REQ-038 Same parameters: nonce_start=0x20, nonce_count=5, target_hit=1 during the 3rd CHECK -> done=1, found=1, nonce=0x22.
REQ-039 nonce_start=0xFFFFFFFF, nonce_count=2, target_hit=0 -> the second nonce is 0x00000000, then done=1, found=0, nonce=0.
REQ-040 abort asserted in the 3rd COMP cycle of pass 1 -> IDLE on the next edge, busy=0, found=0, no done pulse; start while busy is ignored.
REQ-041 Boundary cases at the next edge:
- nonce_count=0 with start -> DONE, then done=1 for one cycle, found=0;
- start and abort together in IDLE -> stays IDLE.
REQ-042 n_rst=0 asserted mid-MSA with default parameters -> every output takes its reset value immediately (asynchronously), done is never asserted, and a later start runs a full 48-cycle MSA.
